// File: rtl/dshot_frame_rx_if.sv
// Signal bundle between a DShot pin source and the dshot_frame_rx decoder.
// The receiver connects through the slave modport.
interface dshot_frame_rx_if;
  logic        dshotPin;
  logic [10:0] throttle;
  logic        telemReq;
  logic [7:0]  outputSpeed;
  logic        frameValid;
  logic        crcErr;
  logic        frameAbort;
  logic        cmdValid;
  logic [5:0]  cmdCode;

  modport master (
    output dshotPin,
    input  throttle, telemReq, outputSpeed, frameValid, crcErr, frameAbort, cmdValid, cmdCode
  );

  modport slave (
    input  dshotPin,
    output throttle, telemReq, outputSpeed, frameValid, crcErr, frameAbort, cmdValid, cmdCode
  );
endinterface

// File: rtl/dshot_frame_rx.sv
// DShot single-channel receiver: pulse-width bit recovery, CRC check, held throttle/speed.
// Define DSHOT_FRAME_RX_CMD_EN to route throttle values 1..47 to cmdValid/cmdCode.
module dshot_frame_rx #(
  parameter int unsigned BIT_THRESH = 60,
  parameter int unsigned MIN_HIGH   = 16,
  parameter int unsigned MAX_HIGH   = 120,
  parameter int unsigned GAP_CYCLES = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  dshot_frame_rx_if.slave  bus
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned THR_W      = 11;
  localparam int unsigned SPEED_W    = 8;
  localparam int unsigned CMD_W      = 6;
  localparam int unsigned CMD_LIMIT  = 48;
  localparam int unsigned BITS_W     = $clog2(FRAME_BITS + 1);
  localparam int unsigned HCNT_W     = $clog2(MAX_HIGH + 2);
  localparam int unsigned LCNT_W     = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_CHECK,
    S_ABORT
  } state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, prev_q;
  logic                    rise, fall;
  logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
  logic [LCNT_W-1:0]       lcnt_q, lcnt_d;
  logic [BITS_W-1:0]       bits_q, bits_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [THR_W-1:0]        throttle_q, throttle_d;
  logic                    telem_q, telem_d;
  logic [SPEED_W-1:0]      speed_q, speed_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    crc_err_q, crc_err_d;
  logic                    frame_abort_q, frame_abort_d;
  logic [THR_W-1:0]        new_thr;
  logic                    crc_ok;
`ifdef DSHOT_FRAME_RX_CMD_EN
  logic                    cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]        cmd_code_q, cmd_code_d;
`endif

  function automatic logic [3:0] crc4(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  // Clamp below the idle offset, then scale the remaining range to 0..249.
  function automatic logic [SPEED_W-1:0] speed_of(input logic [THR_W-1:0] t);
    if (t < THR_W'(CMD_LIMIT)) begin
      return '0;
    end
    return SPEED_W'((t - THR_W'(CMD_LIMIT)) >> 3);
  endfunction

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.dshotPin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (fall) begin
          if (hcnt_q < HCNT_W'(MIN_HIGH))                state_d = S_ABORT;
          else if (bits_q == BITS_W'(FRAME_BITS - 1))    state_d = S_CHECK;
          else                                           state_d = S_LOW;
        end else if (hcnt_q > HCNT_W'(MAX_HIGH)) begin
          state_d = S_ABORT;
        end
      end
      S_LOW: begin
        if (rise)                                   state_d = S_HIGH;
        else if (lcnt_q > LCNT_W'(GAP_CYCLES))      state_d = S_ABORT;
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (lcnt_q > LCNT_W'(GAP_CYCLES)) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    bits_d        = bits_q;
    shift_d       = shift_q;
    throttle_d    = throttle_q;
    telem_d       = telem_q;
    speed_d       = speed_q;
    frame_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    frame_abort_d = 1'b0;
`ifdef DSHOT_FRAME_RX_CMD_EN
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
`endif
    new_thr       = shift_q[FRAME_BITS-1:5];
    crc_ok        = (crc4(shift_q[FRAME_BITS-1:4]) == shift_q[3:0]);

    // Low-time counter runs in every state so a gap already seen carries into ABORT.
    if (sync2_q)                               lcnt_d = '0;
    else if (lcnt_q <= LCNT_W'(GAP_CYCLES))    lcnt_d = lcnt_q + LCNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        bits_d = '0;
      end
      S_HIGH: begin
        if (hcnt_q <= HCNT_W'(MAX_HIGH)) hcnt_d = hcnt_q + HCNT_W'(1);
        if (fall && (hcnt_q >= HCNT_W'(MIN_HIGH))) begin
          shift_d = {shift_q[FRAME_BITS-2:0], (hcnt_q >= HCNT_W'(BIT_THRESH))};
          bits_d  = bits_q + BITS_W'(1);
        end
      end
      S_LOW: begin
        hcnt_d = '0;
      end
      S_CHECK: begin
        bits_d = '0;
        if (!crc_ok) begin
          crc_err_d = 1'b1;
        end
`ifdef DSHOT_FRAME_RX_CMD_EN
        else if ((new_thr != '0) && (new_thr < THR_W'(CMD_LIMIT))) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = CMD_W'(new_thr);
        end
`endif
        else begin
          frame_valid_d = 1'b1;
          throttle_d    = new_thr;
          telem_d       = shift_q[4];
          speed_d       = speed_of(new_thr);
        end
      end
      S_ABORT: begin
        bits_d = '0;
        hcnt_d = '0;
      end
      default: begin
        bits_d = '0;
      end
    endcase

    frame_abort_d = (state_d == S_ABORT) && (state_q != S_ABORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      lcnt_q        <= '0;
      bits_q        <= '0;
      shift_q       <= '0;
      throttle_q    <= '0;
      telem_q       <= 1'b0;
      speed_q       <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      bits_q        <= bits_d;
      shift_q       <= shift_d;
      throttle_q    <= throttle_d;
      telem_q       <= telem_d;
      speed_q       <= speed_d;
      frame_valid_q <= frame_valid_d;
      crc_err_q     <= crc_err_d;
      frame_abort_q <= frame_abort_d;
    end
  end

`ifdef DSHOT_FRAME_RX_CMD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign bus.cmdValid = cmd_valid_q;
  assign bus.cmdCode  = cmd_code_q;
`else
  assign bus.cmdValid = 1'b0;
  assign bus.cmdCode  = '0;
`endif

  assign bus.throttle    = throttle_q;
  assign bus.telemReq    = telem_q;
  assign bus.outputSpeed = speed_q;
  assign bus.frameValid  = frame_valid_q;
  assign bus.crcErr      = crc_err_q;
  assign bus.frameAbort  = frame_abort_q;

endmodule

// File: tb/tb_dshot_frame_rx.sv
// Directed bench for dshot_frame_rx: DShot150 bit timing at one pin sample per clock.
module tb_dshot_frame_rx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   fv_n = 0, ce_n = 0, fa_n = 0, cv_n = 0;
  int   fv_cyc = 0;
  int   fall_cyc = 0;

  always #5 clk = ~clk;

  dshot_frame_rx_if bus ();

  dshot_frame_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.frameValid === 1'b1) begin fv_n++; fv_cyc = cyc; end
    if (bus.crcErr === 1'b1)     ce_n++;
    if (bus.frameAbort === 1'b1) fa_n++;
    if (bus.cmdValid === 1'b1)   cv_n++;
  end

  task automatic hold(input logic v, input int n);
    bus.dshotPin = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] f, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = f[15-i];
      hold(1'b1, b ? 80 : 40);
      fall_cyc = cyc;
      hold(1'b0, b ? 27 : 67);
    end
  endtask

  task automatic send_frame(input logic [15:0] f);
    send_bits(f, 16);
    hold(1'b0, 30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dshotPin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.throttle !== 11'd0)   begin errors++; $display("FAIL reset_throttle got %0d want 0", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd0) begin errors++; $display("FAIL reset_speed got %0d want 0", bus.outputSpeed); end
    checks++; if (bus.telemReq !== 1'b0)    begin errors++; $display("FAIL reset_telem got %b want 0", bus.telemReq); end
    checks++; if ({bus.frameValid, bus.crcErr, bus.frameAbort, bus.cmdValid} !== 4'b0000)
      begin errors++; $display("FAIL reset_pulses got %b want 0000", {bus.frameValid, bus.crcErr, bus.frameAbort, bus.cmdValid}); end
    checks++; if (bus.cmdCode !== 6'd0)     begin errors++; $display("FAIL reset_cmdcode got %0d want 0", bus.cmdCode); end
    rst_n = 1'b1;
    hold(1'b0, 5);
  endtask

  task automatic test_frame_1046();
    int fv0 = fv_n, ce0 = ce_n;
    send_frame(16'h82C6);
    checks++; if (fv_n - fv0 != 1)          begin errors++; $display("FAIL f1046_valid got %0d pulses want 1", fv_n - fv0); end
    checks++; if (ce_n - ce0 != 0)          begin errors++; $display("FAIL f1046_crcerr got %0d pulses want 0", ce_n - ce0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL f1046_throttle got %0d want 1046", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd124) begin errors++; $display("FAIL f1046_speed got %0d want 124", bus.outputSpeed); end
    checks++; if (bus.telemReq !== 1'b0)    begin errors++; $display("FAIL f1046_telem got %b want 0", bus.telemReq); end
    checks++; if ((fv_cyc - fall_cyc) < 1 || (fv_cyc - fall_cyc) > 5)
      begin errors++; $display("FAIL f1046_latency got %0d cycles want 1..5", fv_cyc - fall_cyc); end
  endtask

  task automatic test_extremes();
    int fv0 = fv_n, ce0 = ce_n;
    send_frame(16'hFFEE);
    checks++; if (bus.throttle !== 11'd2047) begin errors++; $display("FAIL max_throttle got %0d want 2047", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd249) begin errors++; $display("FAIL max_speed got %0d want 249", bus.outputSpeed); end
    send_frame(16'h0000);
    checks++; if (bus.throttle !== 11'd0)    begin errors++; $display("FAIL zero_throttle got %0d want 0", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd0)  begin errors++; $display("FAIL zero_speed got %0d want 0", bus.outputSpeed); end
    checks++; if (fv_n - fv0 != 2)           begin errors++; $display("FAIL ext_valid got %0d pulses want 2", fv_n - fv0); end
    checks++; if (ce_n - ce0 != 0)           begin errors++; $display("FAIL ext_crcerr got %0d pulses want 0", ce_n - ce0); end
  endtask

  task automatic test_crc_err();
    int fv0, ce0;
    send_frame(16'h82C6);
    fv0 = fv_n; ce0 = ce_n;
    send_frame(16'h82C7);
    checks++; if (ce_n - ce0 != 1)           begin errors++; $display("FAIL crc_pulse got %0d pulses want 1", ce_n - ce0); end
    checks++; if (fv_n - fv0 != 0)           begin errors++; $display("FAIL crc_valid got %0d pulses want 0", fv_n - fv0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL crc_throttle got %0d want 1046", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd124) begin errors++; $display("FAIL crc_speed got %0d want 124", bus.outputSpeed); end
  endtask

  task automatic test_gap_abort();
    int fv0, fa0;
    send_frame(16'h0000);
    fv0 = fv_n; fa0 = fa_n;
    send_bits(16'h82C6, 8);
    hold(1'b0, 300);
    checks++; if (fa_n - fa0 != 1)           begin errors++; $display("FAIL gap_abort got %0d pulses want 1", fa_n - fa0); end
    checks++; if (bus.throttle !== 11'd0)    begin errors++; $display("FAIL gap_throttle got %0d want 0", bus.throttle); end
    send_frame(16'h82C6);
    checks++; if (fv_n - fv0 != 1)           begin errors++; $display("FAIL gap_next_valid got %0d pulses want 1", fv_n - fv0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL gap_next_throttle got %0d want 1046", bus.throttle); end
  endtask

  task automatic test_glitch_stuck();
    int fv0 = fv_n, fa0 = fa_n;
    send_bits(16'hFFEE, 5);
    hold(1'b1, 10);
    hold(1'b0, 300);
    checks++; if (fa_n - fa0 != 1)           begin errors++; $display("FAIL glitch_abort got %0d pulses want 1", fa_n - fa0); end
    hold(1'b1, 200);
    hold(1'b0, 300);
    checks++; if (fa_n - fa0 != 2)           begin errors++; $display("FAIL stuck_abort got %0d pulses want 2", fa_n - fa0); end
    checks++; if (fv_n - fv0 != 0)           begin errors++; $display("FAIL gs_valid got %0d pulses want 0", fv_n - fv0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL gs_throttle got %0d want 1046", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd124) begin errors++; $display("FAIL gs_speed got %0d want 124", bus.outputSpeed); end
  endtask

  task automatic test_abort_holdoff();
    int fv0 = fv_n, fa0 = fa_n;
    hold(1'b1, 10);
    hold(1'b0, 5);
    send_frame(16'h0000);
    hold(1'b0, 300);
    checks++; if (fv_n - fv0 != 0)           begin errors++; $display("FAIL holdoff_valid got %0d pulses want 0", fv_n - fv0); end
    checks++; if (fa_n - fa0 != 1)           begin errors++; $display("FAIL holdoff_abort got %0d pulses want 1", fa_n - fa0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL holdoff_throttle got %0d want 1046", bus.throttle); end
    send_frame(16'hFFEE);
    checks++; if (bus.throttle !== 11'd2047) begin errors++; $display("FAIL holdoff_next got %0d want 2047", bus.throttle); end
    send_frame(16'h82C6);
  endtask

  task automatic test_cmd();
    int fv0 = fv_n, cv0 = cv_n;
    send_frame(16'h00BB);
`ifdef DSHOT_FRAME_RX_CMD_EN
    checks++; if (cv_n - cv0 != 1)           begin errors++; $display("FAIL cmd_pulse got %0d pulses want 1", cv_n - cv0); end
    checks++; if (bus.cmdCode !== 6'd5)      begin errors++; $display("FAIL cmd_code got %0d want 5", bus.cmdCode); end
    checks++; if (fv_n - fv0 != 0)           begin errors++; $display("FAIL cmd_valid got %0d pulses want 0", fv_n - fv0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL cmd_throttle got %0d want 1046", bus.throttle); end
    checks++; if (bus.telemReq !== 1'b0)     begin errors++; $display("FAIL cmd_telem got %b want 0", bus.telemReq); end
`else
    checks++; if (fv_n - fv0 != 1)           begin errors++; $display("FAIL cmd_valid got %0d pulses want 1", fv_n - fv0); end
    checks++; if (cv_n - cv0 != 0)           begin errors++; $display("FAIL cmd_pulse got %0d pulses want 0", cv_n - cv0); end
    checks++; if (bus.throttle !== 11'd5)    begin errors++; $display("FAIL cmd_throttle got %0d want 5", bus.throttle); end
    checks++; if (bus.telemReq !== 1'b1)     begin errors++; $display("FAIL cmd_telem got %b want 1", bus.telemReq); end
    checks++; if (bus.outputSpeed !== 8'd0)  begin errors++; $display("FAIL cmd_speed got %0d want 0", bus.outputSpeed); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    send_bits(16'hFFEE, 8);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.throttle !== 11'd0)    begin errors++; $display("FAIL rstmid_throttle got %0d want 0", bus.throttle); end
    checks++; if (bus.outputSpeed !== 8'd0)  begin errors++; $display("FAIL rstmid_speed got %0d want 0", bus.outputSpeed); end
    rst_n = 1'b1;
    hold(1'b0, 5);
    fv0 = fv_n;
    send_frame(16'h82C6);
    checks++; if (fv_n - fv0 != 1)           begin errors++; $display("FAIL rstmid_valid got %0d pulses want 1", fv_n - fv0); end
    checks++; if (bus.throttle !== 11'd1046) begin errors++; $display("FAIL rstmid_throttle2 got %0d want 1046", bus.throttle); end
  endtask

  initial begin
    test_reset();
    test_frame_1046();
    test_extremes();
    test_crc_err();
    test_gap_abort();
    test_glitch_stuck();
    test_abort_holdoff();
    test_cmd();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
